// File: rtl/md5_pkg.sv
// Constants and padder state shared by the md5 core and its upstream padder.
package md5_pkg;

  localparam int unsigned MD5_BLOCK_BYTES = 64;
  localparam int unsigned MD5_LEN_OFFSET  = 56;
  localparam logic [7:0]  MD5_PAD_MARKER  = 8'h80;
  localparam int unsigned MD5_PART_W      = 512;

  typedef enum logic [1:0] {
    StFill,
    StEmit,
    StPad,
    StHoldLast
  } md5_pad_state_e;

  // Byte of the little-endian length field that lands at block position pos (56..63).
  function automatic logic [7:0] md5_len_byte(input logic [63:0] len, input int unsigned pos);
    logic [63:0] sh;
    sh = len >> (8 * (pos - MD5_LEN_OFFSET));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/md5_padder.sv
// Packs a byte stream into MD5-padded 512-bit parts for the md5 core.
module md5_padder
  import md5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic                  in_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MD5_PART_W-1:0] out_data,
  output logic                  out_last,
  output logic [63:0]           msg_bits
);

  md5_pad_state_e             state_q;
  logic [7:0]                 blk_q  [MD5_BLOCK_BYTES];
  logic [7:0]                 blk_wd [MD5_BLOCK_BYTES];
  logic [MD5_BLOCK_BYTES-1:0] blk_we;
  logic [5:0]                 idx_q;
  logic [60:0]                byte_cnt_q;
  logic [60:0]                cnt_next;
  logic                       msg_ended_q;
  logic                       marker_done_q;
  logic                       accept;
  logic                       has_byte;
  logic [6:0]                 n_fill;
  logic [63:0]                len_next;

  assign accept   = (state_q == StFill) & in_ready & in_valid;
  assign has_byte = accept & ~in_empty;
  // Bytes in the current block once this transfer lands (0..64).
  assign n_fill   = {1'b0, idx_q} + {6'd0, has_byte};
  assign cnt_next = byte_cnt_q + {60'd0, has_byte};
  assign len_next = {cnt_next, 3'b000};
  assign msg_bits = {byte_cnt_q, 3'b000};

  // Per-byte write enables for the block buffer.
  always_comb begin
    for (int unsigned k = 0; k < MD5_BLOCK_BYTES; k++) begin
      blk_we[k] = 1'b0;
      blk_wd[k] = 8'h00;
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (has_byte && (6'(k) == idx_q)) begin
              blk_we[k] = 1'b1;
              blk_wd[k] = in_data;
            end
            if (in_last && (7'(k) >= n_fill)) begin
              blk_we[k] = 1'b1;
              if (7'(k) == n_fill) begin
                blk_wd[k] = MD5_PAD_MARKER;
              end else if ((n_fill < 7'(MD5_LEN_OFFSET)) && (k >= MD5_LEN_OFFSET)) begin
                blk_wd[k] = md5_len_byte(len_next, k);
              end else begin
                blk_wd[k] = 8'h00;
              end
            end
          end
        end
        StPad: begin
          blk_we[k] = 1'b1;
          if (k < MD5_LEN_OFFSET) begin
            blk_wd[k] = ((k == 0) && !marker_done_q) ? MD5_PAD_MARKER : 8'h00;
          end else begin
            blk_wd[k] = md5_len_byte(msg_bits, k);
          end
        end
        StHoldLast: begin
          if (out_ready) begin
            blk_we[k] = 1'b1;
            blk_wd[k] = 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < MD5_BLOCK_BYTES; k++) blk_q[k] <= 8'h00;
    end else begin
      for (int unsigned k = 0; k < MD5_BLOCK_BYTES; k++) begin
        if (blk_we[k]) blk_q[k] <= blk_wd[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < MD5_BLOCK_BYTES; k++) out_data[8*k +: 8] = blk_q[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StFill;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      msg_ended_q   <= 1'b0;
      marker_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            if (in_last) begin
              byte_cnt_q <= cnt_next;
              idx_q      <= '0;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              if (n_fill < 7'(MD5_LEN_OFFSET)) begin
                out_last <= 1'b1;
                state_q  <= StHoldLast;
              end else begin
                // Tail needs an extra block; a full final block still owes the marker.
                msg_ended_q   <= 1'b1;
                marker_done_q <= (n_fill != 7'(MD5_BLOCK_BYTES));
                state_q       <= StEmit;
              end
            end else if (!in_empty) begin
              byte_cnt_q <= cnt_next;
              idx_q      <= idx_q + 6'd1;
              if (idx_q == 6'(MD5_BLOCK_BYTES - 1)) begin
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                state_q   <= StEmit;
              end
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (msg_ended_q) begin
              state_q <= StPad;
            end else begin
              in_ready <= 1'b1;
              state_q  <= StFill;
            end
          end
        end
        StPad: begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          state_q   <= StHoldLast;
        end
        StHoldLast: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            in_ready      <= 1'b1;
            idx_q         <= '0;
            byte_cnt_q    <= '0;
            msg_ended_q   <= 1'b0;
            marker_done_q <= 1'b0;
            state_q       <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
// Randomised bench for md5_padder against a queue-based MD5 padding model.
module tb_md5_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_empty = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_data;
  logic         out_last;
  logic [63:0]  msg_bits;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_parts[$];
  logic [511:0] got_data[$];
  logic         got_last[$];
  logic [63:0]  got_bits[$];

  always #5 clk = ~clk;

  md5_padder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_empty (in_empty),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .msg_bits (msg_bits)
  );

  // Padded stream = message, 0x80, zeros to 56 mod 64, 8-byte LE bit length; cut into 64-byte parts.
  function automatic void build_model();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] part;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int j = 0; j < 8; j++) p.push_back(bits[8*j +: 8]);
    exp_parts.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int k = 0; k < 64; k++) part[8*k +: 8] = p[64*b + k];
      exp_parts.push_back(part);
    end
  endfunction

  task automatic send(input int gap_pct, input bit end_empty, input bit junk);
    int i = 0;
    int cyc = 0;
    bit done = 0;
    bit xfer;
    int total = msg.size();
    while (!done && cyc < 20000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_empty = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
      if (junk && $urandom_range(9) == 0) begin
        in_empty = 1'b1;
      end else if (i < total) begin
        in_data = msg[i];
        in_last = (i == total - 1) && !end_empty;
      end else begin
        in_empty = 1'b1;
        in_last  = 1'b1;
      end
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        if (in_last) done = 1;
        else if (!in_empty) i++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout sent=%0d of %0d", i, total);
    end
  endtask

  task automatic recv(input int ready_pct);
    int cyc = 0;
    bit done = 0;
    got_data.delete();
    got_last.delete();
    got_bits.delete();
    while (!done && cyc < 20000) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_bits.push_back(msg_bits);
        done = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL recv_timeout parts=%0d", got_data.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({in_ready, out_valid, out_last} !== 3'b000 || out_data !== '0 || msg_bits !== '0) begin
      n_bad++;
      $display("FAIL reset_values got rdy=%b vld=%b last=%b data=%h bits=%h want all zero",
               in_ready, out_valid, out_last, out_data, msg_bits);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL in_ready_rise got %b want 1", in_ready);
    end
  endtask

  task automatic test_known_vectors();
    for (int c = 0; c < 5; c++) begin
      msg.delete();
      case (c)
        1: begin msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63); end
        2: for (int i = 0; i < 55; i++) msg.push_back(8'h41);
        3: for (int i = 0; i < 56; i++) msg.push_back(8'h41);
        4: for (int i = 0; i < 64; i++) msg.push_back(8'h00);
        default: ;
      endcase
      build_model();
      fork
        send(0, 1'b0, 1'b0);
        recv(100);
      join
      n_vec++;
      if (got_data.size() != exp_parts.size()) begin
        n_bad++;
        $display("FAIL known%0d_parts got %0d want %0d", c, got_data.size(), exp_parts.size());
      end else begin
        for (int p = 0; p < got_data.size(); p++) begin
          n_vec++;
          if (got_data[p] !== exp_parts[p] || got_last[p] !== (p == got_data.size() - 1)) begin
            n_bad++;
            $display("FAIL known%0d_part%0d got %h last=%b want %h", c, p, got_data[p],
                     got_last[p], exp_parts[p]);
          end
        end
        n_vec++;
        if (got_bits[$] !== 64'(msg.size()) * 64'd8) begin
          n_bad++;
          $display("FAIL known%0d_msg_bits got %0d want %0d", c, got_bits[$], msg.size() * 8);
        end
        // Spot checks written directly from the padding rules.
        n_vec++;
        case (c)
          0: if (got_data[0] !== 512'h80) begin
               n_bad++; $display("FAIL empty_part got %h want 80", got_data[0]);
             end
          1: if (got_data[0][31:0] !== 32'h80636261 || got_data[0][511:448] !== 64'd24) begin
               n_bad++; $display("FAIL abc_part got %h want 80636261 len 24", got_data[0]);
             end
          2: if (got_data[0][447:440] !== 8'h80 || got_data[0][511:448] !== 64'd440) begin
               n_bad++; $display("FAIL len55_part got %h want marker@55 len 440", got_data[0]);
             end
          3: if (got_data[0][455:448] !== 8'h80 || got_data[1][447:0] !== '0 ||
                 got_data[1][511:448] !== 64'd448) begin
               n_bad++; $display("FAIL len56_parts got %h %h", got_data[0], got_data[1]);
             end
          default: if (got_data[1][7:0] !== 8'h80 || got_data[1][511:448] !== 64'd512) begin
               n_bad++; $display("FAIL len64_part2 got %h want 80 at 0 len 512", got_data[1]);
             end
        endcase
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 16; r++) begin
      int len = $urandom_range(200);
      int gap = (r < 4) ? 0 : $urandom_range(50);
      int rdy = (r < 4) ? 100 : $urandom_range(100, 30);
      bit ee = 1'($urandom_range(1));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      build_model();
      fork
        send(gap, ee, (r >= 4));
        recv(rdy);
      join
      n_vec++;
      if (got_data.size() != exp_parts.size()) begin
        n_bad++;
        $display("FAIL rand%0d_parts len=%0d got %0d want %0d", r, len, got_data.size(),
                 exp_parts.size());
      end else begin
        for (int p = 0; p < got_data.size(); p++) begin
          n_vec++;
          if (got_data[p] !== exp_parts[p] || got_last[p] !== (p == got_data.size() - 1)) begin
            n_bad++;
            $display("FAIL rand%0d_part%0d got %h last=%b want %h", r, p, got_data[p],
                     got_last[p], exp_parts[p]);
          end
        end
        n_vec++;
        if (got_bits[$] !== 64'(len) * 64'd8) begin
          n_bad++;
          $display("FAIL rand%0d_msg_bits got %0d want %0d", r, got_bits[$], len * 8);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    msg.delete();
    for (int i = 0; i < 100; i++) msg.push_back(8'($urandom));
    build_model();
    got_data.delete();
    got_last.delete();
    got_bits.delete();
    fork
      send(0, 1'b0, 1'b0);
      begin
        int cyc = 0;
        bit done = 0;
        bit stalled = 0;
        logic [511:0] held;
        while (!done && cyc < 20000) begin
          out_ready = 1'b1;
          if (out_valid && !stalled) begin
            stalled = 1;
            held = out_data;
            out_ready = 1'b0;
            for (int s = 0; s < 10; s++) begin
              @(posedge clk); #1;
              n_vec++;
              if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall%0d got data=%h rdy=%b vld=%b want data=%h rdy=0 vld=1",
                         s, out_data, in_ready, out_valid, held);
              end
            end
            out_ready = 1'b1;
          end
          if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_bits.push_back(msg_bits);
            done = out_last;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    n_vec++;
    if (got_data.size() != exp_parts.size()) begin
      n_bad++;
      $display("FAIL bp_parts got %0d want %0d", got_data.size(), exp_parts.size());
    end else begin
      for (int p = 0; p < got_data.size(); p++) begin
        n_vec++;
        if (got_data[p] !== exp_parts[p] || got_last[p] !== (p == got_data.size() - 1)) begin
          n_bad++;
          $display("FAIL bp_part%0d got %h want %h", p, got_data[p], exp_parts[p]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int cyc = 0;
    bit xfer;
    bit saw_valid = 0;
    out_ready = 1'b1;
    while (acc < 20 && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      xfer = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (out_valid) saw_valid = 1;
      if (xfer) acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset = 1'b0;
    #2;
    n_vec++;
    if (saw_valid || acc != 20 || in_ready !== 1'b0 || out_valid !== 1'b0 || msg_bits !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_state got acc=%0d early_vld=%b rdy=%b vld=%b bits=%0d", acc,
               saw_valid, in_ready, out_valid, msg_bits);
    end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    build_model();
    fork
      send(0, 1'b0, 1'b0);
      recv(100);
    join
    n_vec++;
    if (got_data.size() != 1 || got_data[0] !== exp_parts[0] || got_bits[0] !== 64'd24) begin
      n_bad++;
      $display("FAIL reset_mid_abc parts=%0d want 1 want data %h", got_data.size(), exp_parts[0]);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
